// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and state encodings for the sequential ALU.
//   alu_op_e    - base integer op, funct3 when i_MulDiv=0
//   muldiv_op_e - M-extension op, funct3 when i_MulDiv=1
//   alu_state_e - control FSM states
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SLL  = 3'b001,
      ALU_SLT  = 3'b010,
      ALU_SLTU = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_SRL  = 3'b101,
      ALU_OR   = 3'b110,
      ALU_AND  = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   // Divide/remainder ops all have funct3[2] set.
   function automatic logic md_is_div(input muldiv_op_e op);
      return op[2];
   endfunction

   // Source1 is taken as signed for MUL/MULH/MULHSU/DIV/REM.
   function automatic logic md_signed1(input muldiv_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // Source2 is taken as signed for MUL/MULH/DIV/REM (MULHSU keeps it unsigned).
   function automatic logic md_signed2(input muldiv_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiplier / restoring divider on
// operand magnitudes, one bit per cycle, with sign fix-up on the last step.
//   clk_i, rst_i  - clock, async active-high reset
//   start_i       - load operands and begin (counter = XLEN-1)
//   flush_i       - abandon the current operation
//   op_i          - M-extension op
//   src1_i/src2_i - raw operands
//   done_c_o      - combinational: final step is happening this cycle
//   result_c_o    - combinational: sign-fixed result, valid with done_c_o
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             flush_i,
   input  muldiv_op_e       op_i,
   input  logic [XLEN-1:0]  src1_i,
   input  logic [XLEN-1:0]  src2_i,
   output logic             done_c_o,
   output logic [XLEN-1:0]  result_c_o
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned AW = 2 * XLEN;

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;
   muldiv_op_e       op_q, op_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;

   logic             s1_neg, s2_neg;
   logic [XLEN-1:0]  mag1, mag2;
   logic [XLEN:0]    madd, dshift, dsub;
   logic [AW-1:0]    mul_step, div_step, step, prod;
   logic [XLEN-1:0]  quo, rem;

   // Operand magnitudes at start.
   always_comb begin
      s1_neg = md_signed1(op_i) & src1_i[XLEN-1];
      s2_neg = md_signed2(op_i) & src2_i[XLEN-1];
      mag1   = s1_neg ? -src1_i : src1_i;
      mag2   = s2_neg ? -src2_i : src2_i;
   end

   // One iteration. Multiply: acc = {partial, multiplier}, add into the upper
   // half and shift right. Divide: acc = {remainder, dividend}, shift left
   // and keep the trial subtraction when it does not borrow.
   always_comb begin
      madd     = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_step = {madd, acc_q[XLEN-1:1]};
      dshift   = acc_q[AW-1:XLEN-1];
      dsub     = dshift - {1'b0, opnd_q};
      div_step = dsub[XLEN] ? {dshift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {dsub[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
      step     = md_is_div(op_q) ? div_step : mul_step;
   end

   // Sign fix-up on the post-step accumulator.
   always_comb begin
      prod = neg_q ? -step : step;
      quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
      rem  = rneg_q ? -step[AW-1:XLEN] : step[AW-1:XLEN];
      case (op_q)
         MD_MUL:                       result_c_o = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result_c_o = prod[AW-1:XLEN];
         MD_DIV, MD_DIVU:              result_c_o = quo;
         MD_REM, MD_REMU:              result_c_o = rem;
         default:                      result_c_o = '0;
      endcase
      done_c_o = busy_q && (cnt_q == '0);
   end

   // Next-state for the iteration registers.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      opnd_d = opnd_q;
      op_d   = op_q;
      neg_d  = neg_q;
      rneg_d = rneg_q;
      if (flush_i) begin
         busy_d = 1'b0;
      end else if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = CW'(XLEN - 1);
         op_d   = op_i;
         rneg_d = s1_neg;
         if (md_is_div(op_i)) begin
            acc_d  = {{XLEN{1'b0}}, mag1};
            opnd_d = mag2;
            // Divide by zero keeps the all-ones quotient unsigned-looking.
            neg_d  = (s1_neg ^ s2_neg) && (src2_i != '0);
         end else begin
            acc_d  = {{XLEN{1'b0}}, mag2};
            opnd_d = mag1;
            neg_d  = s1_neg ^ s2_neg;
         end
      end else if (busy_q) begin
         acc_d = step;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
         op_q   <= MD_MUL;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         op_q   <= op_d;
         neg_q  <= neg_d;
         rneg_q <= rneg_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with base integer ops (1-cycle) and iterative
// M-extension multiply/divide behind a valid/ready port; registered results.
//   i_Clock, i_Reset        - clock, async active-high reset
//   i_Valid / o_Ready       - request handshake
//   i_Flush                 - abort in-flight op, drop same-cycle request
//   i_AluOp, i_AluOpAlt     - funct3 and SUB/SRA select
//   i_MulDiv                - M-extension decode
//   i_Source1, i_Source2    - operands
//   o_Valid                 - one-cycle result pulse
//   o_Output, o_Zero        - result and zero flag (held)
//   o_LessThan[Unsigned]    - compare flags, base ops only
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter bit          EARLY_OUT = 1'b1
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic             i_Valid,
   output logic             o_Ready,
   input  logic             i_Flush,
   input  logic [2:0]       i_AluOp,
   input  logic             i_AluOpAlt,
   input  logic             i_MulDiv,
   input  logic [XLEN-1:0]  i_Source1,
   input  logic [XLEN-1:0]  i_Source2,
   output logic             o_Valid,
   output logic [XLEN-1:0]  o_Output,
   output logic             o_Zero,
   output logic             o_LessThan,
   output logic             o_LessThanUnsigned
);

   localparam int unsigned SHW = $clog2(XLEN);

   alu_state_e       state_q, state_d;
   logic [XLEN-1:0]  out_q, out_d;
   logic             zero_q, zero_d;
   logic             lt_q, lt_d;
   logic             ltu_q, ltu_d;
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;

   logic [XLEN:0]    diff;
   logic             ovf, lt_c, ltu_c;
   logic [SHW-1:0]   shamt;
   logic [XLEN-1:0]  base_res;
   logic             div_zero, div_ovf, early;
   logic [XLEN-1:0]  special_res;
   logic             accept, md_start, md_done;
   logic [XLEN-1:0]  md_res;

   // Base ALU; compare flags come from the XLEN+1-bit subtract.
   always_comb begin
      diff  = {1'b0, i_Source1} - {1'b0, i_Source2};
      ovf   = (i_Source1[XLEN-1] ^ i_Source2[XLEN-1]) & (diff[XLEN-1] ^ i_Source1[XLEN-1]);
      lt_c  = diff[XLEN-1] ^ ovf;
      ltu_c = diff[XLEN];
      shamt = i_Source2[SHW-1:0];
      case (alu_op_e'(i_AluOp))
         ALU_ADD:  base_res = i_AluOpAlt ? diff[XLEN-1:0] : i_Source1 + i_Source2;
         ALU_SLL:  base_res = i_Source1 << shamt;
         ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, lt_c};
         ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, ltu_c};
         ALU_XOR:  base_res = i_Source1 ^ i_Source2;
         ALU_SRL:  base_res = i_AluOpAlt ? $unsigned($signed(i_Source1) >>> shamt)
                                         : i_Source1 >> shamt;
         ALU_OR:   base_res = i_Source1 | i_Source2;
         ALU_AND:  base_res = i_Source1 & i_Source2;
         default:  base_res = '0;
      endcase
   end

   // Divide-by-zero and signed-overflow results, usable without iterating.
   always_comb begin
      div_zero = (i_Source2 == '0);
      div_ovf  = !i_AluOp[0] && (i_Source1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_Source2);
      early    = EARLY_OUT && i_MulDiv && i_AluOp[2] && (div_zero || div_ovf);
      if (i_AluOp[1]) special_res = div_zero ? i_Source1 : '0;
      else            special_res = div_zero ? '1 : i_Source1;
   end

   alu_muldiv_iter #(
      .XLEN (XLEN)
   ) u_muldiv (
      .clk_i      (i_Clock),
      .rst_i      (i_Reset),
      .start_i    (md_start),
      .flush_i    (i_Flush),
      .op_i       (muldiv_op_e'(i_AluOp)),
      .src1_i     (i_Source1),
      .src2_i     (i_Source2),
      .done_c_o   (md_done),
      .result_c_o (md_res)
   );

   // Control FSM: next state, result capture and iterator start.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      lt_d     = lt_q;
      ltu_d    = ltu_q;
      md_start = 1'b0;
      accept   = i_Valid && (state_q != ST_RUN) && !i_Flush;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               if (!i_MulDiv) begin
                  out_d   = base_res;
                  lt_d    = lt_c;
                  ltu_d   = ltu_c;
                  state_d = ST_DONE;
               end else if (early) begin
                  out_d   = special_res;
                  lt_d    = 1'b0;
                  ltu_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  md_start = 1'b1;
                  state_d  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (i_Flush) begin
               state_d = ST_IDLE;
            end else if (md_done) begin
               out_d   = md_res;
               lt_d    = 1'b0;
               ltu_d   = 1'b0;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      zero_d  = (out_d == '0);
      valid_d = (state_d == ST_DONE);
      ready_d = (state_d != ST_RUN);
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         zero_q  <= 1'b1;
         lt_q    <= 1'b0;
         ltu_q   <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
         lt_q    <= lt_d;
         ltu_q   <= ltu_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign o_Ready            = ready_q;
   assign o_Valid            = valid_q;
   assign o_Output           = out_q;
   assign o_Zero             = zero_q;
   assign o_LessThan         = lt_q;
   assign o_LessThanUnsigned = ltu_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (XLEN=32, EARLY_OUT=1).
module tb_alu_seq;

   logic        clk;
   logic        i_Reset;
   logic        i_Valid;
   logic        o_Ready;
   logic        i_Flush;
   logic [2:0]  i_AluOp;
   logic        i_AluOpAlt;
   logic        i_MulDiv;
   logic [31:0] i_Source1;
   logic [31:0] i_Source2;
   logic        o_Valid;
   logic [31:0] o_Output;
   logic        o_Zero;
   logic        o_LessThan;
   logic        o_LessThanUnsigned;

   typedef struct {
      string       tag;
      logic [31:0] out;
      logic        lt;
      logic        ltu;
      int          cyc;
   } sb_t;

   sb_t sb[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = 0;

   alu_seq #(
      .XLEN      (32),
      .EARLY_OUT (1'b1)
   ) dut (
      .i_Clock            (clk),
      .i_Reset            (i_Reset),
      .i_Valid            (i_Valid),
      .o_Ready            (o_Ready),
      .i_Flush            (i_Flush),
      .i_AluOp            (i_AluOp),
      .i_AluOpAlt         (i_AluOpAlt),
      .i_MulDiv           (i_MulDiv),
      .i_Source1          (i_Source1),
      .i_Source2          (i_Source2),
      .o_Valid            (o_Valid),
      .o_Output           (o_Output),
      .o_Zero             (o_Zero),
      .o_LessThan         (o_LessThan),
      .o_LessThanUnsigned (o_LessThanUnsigned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b000:  return alt ? a - b : a + b;
         3'b001:  return a << b[4:0];
         3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b011:  return (a < b) ? 32'd1 : 32'd0;
         3'b100:  return a ^ b;
         3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb2, ua, ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      ua  = longint'({32'h0, a});
      ub  = longint'({32'h0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'b000: begin p = 64'(sa * sb2); return p[31:0]; end
         3'b001: begin p = 64'(sa * sb2); return p[63:32]; end
         3'b010: begin p = 64'(sa * ub);  return p[63:32]; end
         3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb2);
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb2);
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   // Drive one request, wait for acceptance, and queue its expected result.
   task automatic issue(input logic md, input logic [2:0] op, input logic alt,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit track, input string tag);
      sb_t e;
      bit  special;
      @(negedge clk);
      i_Valid    = 1'b1;
      i_MulDiv   = md;
      i_AluOp    = op;
      i_AluOpAlt = alt;
      i_Source1  = a;
      i_Source2  = b;
      for (int i = 0; i < 200 && !o_Ready; i++) @(negedge clk);
      if (!o_Ready) begin
         check({tag, "_accept"}, 64'(o_Ready), 64'd1);
         return;
      end
      special = md && op[2] &&
                ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      if (track) begin
         e.tag = tag;
         e.out = exp;
         e.lt  = md ? 1'b0 : ($signed(a) < $signed(b));
         e.ltu = md ? 1'b0 : (a < b);
         e.cyc = cyc + ((!md || special) ? 1 : 33);
         sb.push_back(e);
      end
   endtask

   task automatic drop();
      @(negedge clk);
      i_Valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(o_Valid), 64'd0);
      check({tag, "_out"},   64'(o_Output), 64'd0);
      check({tag, "_zero"},  64'(o_Zero), 64'd1);
      check({tag, "_lt"},    64'(o_LessThan), 64'd0);
      check({tag, "_ltu"},   64'(o_LessThanUnsigned), 64'd0);
      check({tag, "_ready"}, 64'(o_Ready), 64'd1);
   endtask

   // Result monitor: every o_Valid pulse must match the head of the scoreboard.
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         if (!i_Reset && o_Valid) begin
            if (sb.size() == 0) begin
               check("spurious_valid", 64'(o_Valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check({e.tag, "_out"},  64'(o_Output), 64'(e.out));
               check({e.tag, "_zero"}, 64'(o_Zero), 64'(e.out == 32'h0));
               check({e.tag, "_lt"},   64'(o_LessThan), 64'(e.lt));
               check({e.tag, "_ltu"},  64'(o_LessThanUnsigned), 64'(e.ltu));
               check({e.tag, "_cyc"},  64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        md, alt;
      logic [2:0]  op;
      logic [31:0] a, b;
      i_Reset = 1'b1; i_Valid = 1'b0; i_Flush = 1'b0;
      i_AluOp = 3'b000; i_AluOpAlt = 1'b0; i_MulDiv = 1'b0;
      i_Source1 = '0; i_Source2 = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      i_Reset = 1'b0;

      // Base ops, back-to-back.
      issue(0, 3'b000, 0, 32'd5, 32'hFFFF_FFFD, 32'd2,          1, "add");
      issue(0, 3'b000, 1, 32'd3, 32'd5,         32'hFFFF_FFFE,  1, "sub");
      issue(0, 3'b010, 0, 32'd3, 32'd5,         32'd1,          1, "slt");
      issue(0, 3'b011, 0, 32'd3, 32'd5,         32'd1,          1, "sltu");
      issue(0, 3'b101, 1, 32'h8000_0000, 32'd4, 32'hF800_0000,  1, "sra");
      issue(0, 3'b101, 0, 32'h8000_0000, 32'd4, 32'h0800_0000,  1, "srl");
      issue(0, 3'b100, 0, 32'h1234_5678, 32'h1234_5678, 32'h0,  1, "xor_zero");
      drop();
      drain();

      // MULH with o_Ready low through RUN.
      issue(1, 3'b001, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, "mulh");
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (k == 0) i_Valid = 1'b0;
         check("ready_run", 64'(o_Ready), 64'd0);
      end
      drain();
      issue(1, 3'b011, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "mulhu");
      drop();
      drain();

      // MUL then ADD accepted in its DONE cycle.
      issue(1, 3'b000, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1, "mul");
      issue(0, 3'b000, 0, 32'd1, 32'd1, 32'd2, 1, "b2b_add");
      drop();
      drain();

      // Divide special cases (early out) and signed divide.
      issue(1, 3'b100, 0, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
      issue(1, 3'b110, 0, 32'd7, 32'd0, 32'd7,         1, "rem_by0");
      issue(1, 3'b100, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      issue(1, 3'b110, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem_ovf");
      issue(1, 3'b100, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, "div_neg");
      issue(1, 3'b110, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, "rem_neg");
      issue(1, 3'b101, 0, 32'd100, 32'd7, 32'd14, 1, "divu");
      issue(1, 3'b111, 0, 32'd100, 32'd7, 32'd2,  1, "remu");
      drop();
      drain();

      // Flush during RUN: no result, back to ready.
      issue(1, 3'b100, 0, 32'd100, 32'd7, 32'd0, 0, "flushed");
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) i_Valid = 1'b0;
      end
      i_Flush = 1'b1;
      @(negedge clk);
      i_Flush = 1'b0;
      check("flush_valid", 64'(o_Valid), 64'd0);
      check("flush_ready", 64'(o_Ready), 64'd1);
      repeat (40) @(negedge clk);

      // Flush with a request in the same cycle: request dropped.
      i_Valid = 1'b1; i_MulDiv = 1'b0; i_AluOp = 3'b000; i_AluOpAlt = 1'b0;
      i_Source1 = 32'd1; i_Source2 = 32'd1; i_Flush = 1'b1;
      @(negedge clk);
      i_Valid = 1'b0; i_Flush = 1'b0;
      check("flush_drop_valid", 64'(o_Valid), 64'd0);
      repeat (3) @(negedge clk);
      issue(0, 3'b000, 0, 32'd10, 32'd20, 32'd30, 1, "post_flush");
      drop();
      drain();

      // Async reset in the middle of a divide.
      issue(1, 3'b100, 0, 32'd1000, 32'd3, 32'd0, 0, "reset_div");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) i_Valid = 1'b0;
      end
      i_Reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      i_Reset = 1'b0;
      repeat (40) @(negedge clk);

      // Random mix against the reference models, biased to edge operands.
      for (int n = 0; n < 24; n++) begin
         md  = 1'($urandom_range(0, 1));
         op  = 3'($urandom_range(0, 7));
         alt = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       a = 32'h0;
            1:       a = 32'hFFFF_FFFF;
            2:       a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 40));
            default: b = $urandom;
         endcase
         issue(md, op, alt, a, b, md ? ref_md(op, a, b) : ref_alu(op, alt, a, b), 1, "rand");
      end
      drop();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
